// File: rtl/opfetch_pkg.sv
// Shared definitions for the operand-fetch sequencer: FSM states, register
// index map and the illegal-index predicate.
package opfetch_pkg;

    typedef enum logic [2:0] {
        IDLE,
        RD_A,
        RD_B,
        CAP_B,
        HOLD
    } state_t;

    localparam int REG_COUNT = 16;
    localparam int IDX_W     = 5;

    // G bank occupies 0x00-0x07, A bank 0x08-0x0F; bit 4 is never a real register
    localparam logic [IDX_W-1:0] G0 = 5'h00;
    localparam logic [IDX_W-1:0] G1 = 5'h01;
    localparam logic [IDX_W-1:0] G2 = 5'h02;
    localparam logic [IDX_W-1:0] G3 = 5'h03;
    localparam logic [IDX_W-1:0] G4 = 5'h04;
    localparam logic [IDX_W-1:0] G5 = 5'h05;
    localparam logic [IDX_W-1:0] G6 = 5'h06;
    localparam logic [IDX_W-1:0] G7 = 5'h07;
    localparam logic [IDX_W-1:0] A0 = 5'h08;
    localparam logic [IDX_W-1:0] A1 = 5'h09;
    localparam logic [IDX_W-1:0] A2 = 5'h0A;
    localparam logic [IDX_W-1:0] A3 = 5'h0B;
    localparam logic [IDX_W-1:0] A4 = 5'h0C;
    localparam logic [IDX_W-1:0] A5 = 5'h0D;
    localparam logic [IDX_W-1:0] A6 = 5'h0E;
    localparam logic [IDX_W-1:0] A7 = 5'h0F;

    function automatic logic idx_illegal(input logic [IDX_W-1:0] sel);
        return sel[IDX_W-1];
    endfunction

endpackage

// File: rtl/opfetch.sv
// Operand-fetch sequencer: reads one or two operands from an external
// registered-read bank and arbitrates writebacks into the same bank.
module opfetch
    import opfetch_pkg::*;
#(
    parameter int XLEN  = 64,
    parameter int SEL_W = 5
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [SEL_W-1:0] req_rs1,
    input  logic [SEL_W-1:0] req_rs2,
    input  logic             req_two,
    input  logic             wb_valid,
    output logic             wb_ready,
    input  logic [SEL_W-1:0] wb_sel,
    input  logic [XLEN-1:0]  wb_data,
    output logic             rb_we,
    output logic [SEL_W-1:0] rb_sel,
    output logic [XLEN-1:0]  rb_wdata,
    input  logic [XLEN-1:0]  rb_rdata,
    output logic             op_valid,
    input  logic             op_ready,
    output logic [XLEN-1:0]  op_a,
    output logic [XLEN-1:0]  op_b,
    output logic             op_err
);

    state_t           state, state_nx;
    logic [SEL_W-1:0] rs1_q, rs2_q;
    logic             two_q;

    always_ff @(posedge clk) begin
        if (!reset) begin
            state  <= IDLE;
            op_a   <= '0;
            op_b   <= '0;
            op_err <= 1'b0;
        end else begin
            state <= state_nx;
            case (state)
                RD_B: begin
                    op_a   <= idx_illegal(rs1_q) ? '0 : rb_rdata;
                    op_err <= idx_illegal(rs1_q) | (two_q & idx_illegal(rs2_q));
                    if (!two_q)
                        op_b <= '0;
                end
                CAP_B: op_b <= idx_illegal(rs2_q) ? '0 : rb_rdata;
                default: ;
            endcase
        end
    end

    // Request fields are only meaningful once accepted, so they carry no reset
    always_ff @(posedge clk) begin
        if (state == IDLE && !wb_valid && req_valid) begin
            rs1_q <= req_rs1;
            rs2_q <= req_rs2;
            two_q <= req_two;
        end
    end

    always_comb begin
        state_nx  = state;
        req_ready = 1'b0;
        wb_ready  = 1'b0;
        rb_we     = 1'b0;
        rb_sel    = '0;
        rb_wdata  = '0;
        case (state)
            IDLE: begin
                if (wb_valid) begin
                    wb_ready = 1'b1;
                    rb_we    = !idx_illegal(wb_sel);
                    rb_sel   = wb_sel;
                    rb_wdata = wb_data;
                end else begin
                    req_ready = 1'b1;
                    if (req_valid)
                        state_nx = RD_A;
                end
            end
            RD_A: begin
                rb_sel   = rs1_q;
                state_nx = RD_B;
            end
            RD_B: begin
                rb_sel   = rs2_q;
                state_nx = two_q ? CAP_B : HOLD;
            end
            CAP_B: state_nx = HOLD;
            HOLD: begin
                // Operands are already captured, so a writeback here cannot disturb them
                wb_ready = 1'b1;
                if (wb_valid) begin
                    rb_we    = !idx_illegal(wb_sel);
                    rb_sel   = wb_sel;
                    rb_wdata = wb_data;
                end
                if (op_ready)
                    state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase
        if (!reset) begin
            req_ready = 1'b0;
            wb_ready  = 1'b0;
            rb_we     = 1'b0;
            rb_sel    = '0;
            rb_wdata  = '0;
        end
    end

    assign op_valid = (state == HOLD);

endmodule

// File: tb/tb_opfetch.sv
// Directed bench for opfetch with a behavioural registered-read register bank.
module tb_opfetch;

    localparam int XLEN  = 64;
    localparam int SEL_W = 5;
    localparam logic [63:0] BASE = 64'hC0DE_0000_0000_0000;

    logic             clk = 1'b0;
    logic             reset;
    logic             req_valid, req_ready, req_two;
    logic [SEL_W-1:0] req_rs1, req_rs2;
    logic             wb_valid, wb_ready;
    logic [SEL_W-1:0] wb_sel;
    logic [XLEN-1:0]  wb_data;
    logic             rb_we;
    logic [SEL_W-1:0] rb_sel;
    logic [XLEN-1:0]  rb_wdata, rb_rdata;
    logic             op_valid, op_ready, op_err;
    logic [XLEN-1:0]  op_a, op_b;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    opfetch #(.XLEN(XLEN), .SEL_W(SEL_W)) dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_rs1(req_rs1), .req_rs2(req_rs2), .req_two(req_two),
        .wb_valid(wb_valid), .wb_ready(wb_ready),
        .wb_sel(wb_sel), .wb_data(wb_data),
        .rb_we(rb_we), .rb_sel(rb_sel), .rb_wdata(rb_wdata), .rb_rdata(rb_rdata),
        .op_valid(op_valid), .op_ready(op_ready),
        .op_a(op_a), .op_b(op_b), .op_err(op_err)
    );

    // Register bank model: active-high reset, registered read, 32 slots so that
    // illegal indices return recognisable junk instead of zero.
    logic [XLEN-1:0] mem [32];
    logic            bank_rst;
    assign bank_rst = ~reset;

    always @(posedge clk) begin
        if (bank_rst) begin
            rb_rdata <= '0;
            for (int i = 16; i < 32; i++) mem[i] <= 64'hBAD0_0000_0000_0000 | 64'(i);
        end else if (rb_we) begin
            mem[rb_sel] <= rb_wdata;
        end else begin
            rb_rdata <= mem[rb_sel];
        end
    end

    typedef struct {
        logic [SEL_W-1:0] rs1;
        logic [SEL_W-1:0] rs2;
        logic             two;
        logic [XLEN-1:0]  exp_a;
        logic [XLEN-1:0]  exp_b;
        logic             exp_err;
        int               exp_lat;
    } vec_t;

    vec_t vecs [7];

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic wb(input logic [SEL_W-1:0] sel, input logic [XLEN-1:0] data, input logic exp_we);
        @(negedge clk);
        wb_valid = 1'b1;
        wb_sel   = sel;
        wb_data  = data;
        #1;
        chk($sformatf("wb_ready sel=%h", sel), 64'(wb_ready), 64'd1);
        chk($sformatf("rb_we sel=%h", sel), 64'(rb_we), 64'(exp_we));
        @(negedge clk);
        wb_valid = 1'b0;
    endtask

    // Leaves the bench at the first negedge after the acceptance edge.
    task automatic issue(input logic [SEL_W-1:0] rs1, input logic [SEL_W-1:0] rs2, input logic two);
        @(negedge clk);
        req_valid = 1'b1;
        req_rs1   = rs1;
        req_rs2   = rs2;
        req_two   = two;
        #1;
        chk("req_ready", 64'(req_ready), 64'd1);
        @(negedge clk);
        req_valid = 1'b0;
    endtask

    // Latency counts cycles after the acceptance edge: the first is 1.
    task automatic collect(input string nm, input logic [XLEN-1:0] ea, input logic [XLEN-1:0] eb,
                           input logic ee, input int elat);
        int lat = 1;
        while (!op_valid && lat < 20) begin
            @(negedge clk);
            lat++;
        end
        chk({nm, " latency"}, 64'(lat), 64'(elat));
        chk({nm, " op_a"}, op_a, ea);
        chk({nm, " op_b"}, op_b, eb);
        chk({nm, " op_err"}, 64'(op_err), 64'(ee));
        op_ready = 1'b1;
        @(negedge clk);
        op_ready = 1'b0;
        chk({nm, " op_valid drop"}, 64'(op_valid), 64'd0);
    endtask

    initial begin
        int t1, t2, n;
        logic seen;

        vecs[0] = '{5'h03, 5'h0A, 1'b1, 64'h11,        64'h22,        1'b0, 4};
        vecs[1] = '{5'h05, 5'h00, 1'b0, BASE + 64'h05, 64'h0,         1'b0, 3};
        vecs[2] = '{5'h0F, 5'h00, 1'b1, BASE + 64'h0F, BASE,          1'b0, 4};
        vecs[3] = '{5'h03, 5'h12, 1'b1, 64'h11,        64'h0,         1'b1, 4};
        vecs[4] = '{5'h15, 5'h07, 1'b1, 64'h0,         BASE + 64'h07, 1'b1, 4};
        vecs[5] = '{5'h1F, 5'h10, 1'b0, 64'h0,         64'h0,         1'b1, 3};
        vecs[6] = '{5'h08, 5'h03, 1'b0, BASE + 64'h08, 64'h0,         1'b0, 3};

        // Reset with both handshakes requested
        reset = 1'b0; req_valid = 1'b1; req_rs1 = 5'h03; req_rs2 = 5'h0A; req_two = 1'b1;
        wb_valid = 1'b1; wb_sel = 5'h03; wb_data = 64'hFFFF; op_ready = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        chk("rst req_ready", 64'(req_ready), 64'd0);
        chk("rst wb_ready", 64'(wb_ready), 64'd0);
        chk("rst rb_we", 64'(rb_we), 64'd0);
        chk("rst rb_sel", 64'(rb_sel), 64'd0);
        chk("rst rb_wdata", rb_wdata, 64'd0);
        chk("rst op_valid", 64'(op_valid), 64'd0);
        chk("rst op_a", op_a, 64'd0);
        chk("rst op_b", op_b, 64'd0);
        chk("rst op_err", 64'(op_err), 64'd0);
        req_valid = 1'b0; wb_valid = 1'b0;
        @(negedge clk);
        reset = 1'b1;

        for (int i = 0; i < 16; i++) wb(5'(i), BASE + 64'(i), 1'b1);
        wb(5'h03, 64'h11, 1'b1);
        wb(5'h0A, 64'h22, 1'b1);
        wb(5'h1F, 64'hDEAD, 1'b0);

        for (int i = 0; i < 7; i++) begin
            issue(vecs[i].rs1, vecs[i].rs2, vecs[i].two);
            collect($sformatf("vec%0d", i), vecs[i].exp_a, vecs[i].exp_b, vecs[i].exp_err, vecs[i].exp_lat);
        end

        // Writeback and request together: write wins, request taken the cycle after
        @(negedge clk);
        wb_valid = 1'b1; wb_sel = 5'h01; wb_data = 64'h55;
        req_valid = 1'b1; req_rs1 = 5'h01; req_rs2 = 5'h00; req_two = 1'b0;
        #1;
        chk("coll req_ready", 64'(req_ready), 64'd0);
        chk("coll wb_ready", 64'(wb_ready), 64'd1);
        chk("coll rb_we", 64'(rb_we), 64'd1);
        @(negedge clk);
        wb_valid = 1'b0;
        #1;
        chk("coll req_ready next", 64'(req_ready), 64'd1);
        @(negedge clk);
        req_valid = 1'b0;
        collect("coll G1", 64'h55, 64'h0, 1'b0, 3);

        // Stall in HOLD with a writeback to the rs1 register
        issue(5'h04, 5'h06, 1'b1);
        n = 1;
        while (!op_valid && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk("hold latency", 64'(n), 64'd4);
        for (int c = 0; c < 6; c++) begin
            if (c == 1) begin
                wb_valid = 1'b1; wb_sel = 5'h04; wb_data = 64'h99;
                #1;
                chk("hold wb_ready", 64'(wb_ready), 64'd1);
                chk("hold rb_we", 64'(rb_we), 64'd1);
            end
            @(negedge clk);
            wb_valid = 1'b0;
            chk($sformatf("hold op_valid c%0d", c), 64'(op_valid), 64'd1);
            chk($sformatf("hold op_a c%0d", c), op_a, BASE + 64'h04);
            chk($sformatf("hold op_b c%0d", c), op_b, BASE + 64'h06);
        end
        op_ready = 1'b1;
        @(negedge clk);
        op_ready = 1'b0;
        chk("hold release", 64'(op_valid), 64'd0);
        issue(5'h04, 5'h00, 1'b0);
        collect("G4 after wb", 64'h99, 64'h0, 1'b0, 3);

        // Reset while in RD_B discards the request
        issue(5'h03, 5'h0A, 1'b1);
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        seen = op_valid;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            seen = seen | op_valid;
        end
        chk("midreset no delivery", 64'(seen), 64'd0);
        issue(5'h03, 5'h0A, 1'b1);
        collect("after reset", 64'h11, 64'h22, 1'b0, 4);

        // Back-to-back requests with op_ready held high
        @(negedge clk);
        req_valid = 1'b1; req_rs1 = 5'h03; req_rs2 = 5'h0A; req_two = 1'b1; op_ready = 1'b1;
        t1 = 0;
        while (!op_valid && t1 < 20) begin
            @(negedge clk);
            t1++;
        end
        @(negedge clk);
        t2 = t1 + 1;
        while (!op_valid && t2 < 40) begin
            @(negedge clk);
            t2++;
        end
        req_valid = 1'b0;
        chk("throughput period", 64'(t2 - t1), 64'd5);
        chk("throughput op_b", op_b, 64'h22);
        @(negedge clk);
        op_ready = 1'b0;
        repeat (2) @(negedge clk);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
